// File: rtl/sport_rx_if.sv
// Receiver-side inputs and word read port of the SPORT receive controller.
interface sport_rx_if;
  logic        fs;
  logic        take_this;
  logic [7:0]  lane0;
  logic [7:0]  lane1;
  logic [7:0]  lane2;
  logic [7:0]  lane3;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output fs, take_this, lane0, lane1, lane2, lane3, word_ready,
    input  word_data, word_valid
  );

  modport slave (
    input  fs, take_this, lane0, lane1, lane2, lane3, word_ready,
    output word_data, word_valid
  );
endinterface

// File: rtl/sport_rx_ctrl.sv
// Frames the 4-lane SPORT byte receiver output into 32-bit words and queues them in a FIFO.
// Optional stall detection is compiled in with SPORT_CTRL_TIMEOUT_EN.
module sport_rx_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        sport_clk,
  input  logic                        rst_n,
  input  logic                        enable,
  sport_rx_if.slave                   rx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            frame_cnt,
  output logic                        short_err,
  output logic                        overrun,
  input  logic                        err_clr,
  output logic                        link_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ARMED, RECV, PUSH, DONE} state_t;

  state_t           state, state_nxt;
  logic             take_q;
  logic             take_edge;
  logic [7:0]       bit_cnt;
  logic             push, short_set;
  logic             pop, full, wr_en;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      mem [FIFO_DEPTH];

  // Only the rising edge of the byte-complete level matters; it stays high until fs returns.
  assign take_edge = rx.take_this & ~take_q;

  always_ff @(posedge sport_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      take_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      take_q <= rx.take_this;
    end
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    short_set = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  state_nxt = ARMED;
        ARMED: if (!rx.fs) state_nxt = RECV;
        RECV: begin
          if (take_edge) begin
            state_nxt = PUSH;
          end else if (rx.fs) begin
            short_set = 1'b1;
            state_nxt = ARMED;
          end
        end
        PUSH: begin
          push      = 1'b1;
          state_nxt = DONE;
        end
        DONE:  if (rx.fs) state_nxt = ARMED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sport_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (state == ARMED && state_nxt == RECV) begin
      bit_cnt <= 8'd1;
    end else if (state == RECV && !rx.fs && bit_cnt != 8'hFF) begin
      bit_cnt <= bit_cnt + 8'd1;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
    end
  end

  // FIFO: lanes are sampled in the PUSH cycle, one cycle after the take edge.
  assign pop   = (count != '0) & rx.word_ready;
  assign full  = (count == FULL_LVL);
  assign wr_en = push & (~full | pop);

  always_ff @(posedge sport_clk) begin
    if (wr_en) mem[wr_ptr] <= {rx.lane3, rx.lane2, rx.lane1, rx.lane0};
  end

  always_ff @(posedge sport_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      short_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push) frame_cnt <= frame_cnt + 1'b1;
      // A new error event takes priority over a coincident clear.
      if (push & full & ~pop) overrun <= 1'b1;
      else if (err_clr)       overrun <= 1'b0;
      if (short_set)          short_err <= 1'b1;
      else if (err_clr)       short_err <= 1'b0;
    end
  end

  assign rx.word_valid = (count != '0);
  assign rx.word_data  = rx.word_valid ? mem[rd_ptr] : 32'h0;
  assign fifo_level    = count;

`ifdef SPORT_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_run;

  assign to_run = (state == ARMED || state == DONE) && state_nxt != RECV;

  always_ff @(posedge sport_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt       <= '0;
      link_timeout <= 1'b0;
    end else if (state == IDLE && state_nxt == ARMED) begin
      to_cnt       <= '0;
      link_timeout <= 1'b0;
    end else begin
      if (state == ARMED && state_nxt == RECV) to_cnt <= '0;
      else if (to_run && to_cnt != TO_MAX)     to_cnt <= to_cnt + 1'b1;
      if (to_run && to_cnt == TO_LAST) link_timeout <= 1'b1;
      else if (err_clr)                link_timeout <= 1'b0;
    end
  end
`else
  assign link_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sport_rx_ctrl.sv
// Directed bench for sport_rx_ctrl: framing, FIFO order/overrun, short frames, reset and timeout.
module tb_sport_rx_ctrl;

  logic        sport_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        err_clr;
  logic [3:0]  fifo_level;
  logic [15:0] frame_cnt;
  logic        short_err, overrun, link_timeout;
  int          n_chk  = 0;
  int          n_pass = 0;

  sport_rx_if rx ();

  sport_rx_ctrl #(.FIFO_DEPTH(8), .CNT_W(16), .TIMEOUT_CYC(16)) dut (
    .sport_clk    (sport_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .rx           (rx),
    .fifo_level   (fifo_level),
    .frame_cnt    (frame_cnt),
    .short_err    (short_err),
    .overrun      (overrun),
    .err_clr      (err_clr),
    .link_timeout (link_timeout)
  );

  always #5 sport_clk = ~sport_clk;

  task automatic step();
    @(posedge sport_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] wd(input logic [7:0] b);
    return {b + 8'h30, b + 8'h20, b + 8'h10, b};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    rx.fs = 1'b1;
    rx.take_this = 1'b0;
    rx.word_ready = 1'b0;
    err_clr = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  // Starts from ARMED; returns in ARMED after fs has risen again.
  task automatic send_frame(input logic [31:0] w, input int nbits, input bit pop_in_push,
                            input bit chk_lat);
    rx.fs = 1'b0;
    repeat (nbits) step();
    {rx.lane3, rx.lane2, rx.lane1, rx.lane0} = w;
    rx.take_this = 1'b1;
    step();
    if (chk_lat) chk("lat_n1_valid", 32'(rx.word_valid), 32'd0);
    if (pop_in_push) rx.word_ready = 1'b1;
    step();
    rx.word_ready = 1'b0;
    if (chk_lat) chk("lat_n2_valid", 32'(rx.word_valid), 32'd1);
    rx.fs = 1'b1;
    rx.take_this = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    err_clr = 1'b0;
    rx.fs = 1'b1;
    rx.take_this = 1'b0;
    rx.word_ready = 1'b0;
    {rx.lane3, rx.lane2, rx.lane1, rx.lane0} = 32'h0;
    repeat (2) step();
    chk("rst_valid", 32'(rx.word_valid), 32'd0);
    chk("rst_data", rx.word_data, 32'h0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_frames", 32'(frame_cnt), 32'd0);
    chk("rst_flags", {29'd0, short_err, overrun, link_timeout}, 32'd0);
    enable = 1'b1;
    rst_n = 1'b1;
    repeat (2) step();

    // Single frame with latency check
    send_frame(32'hF00F3CA5, 8, 1'b0, 1'b1);
    chk("frame_data", rx.word_data, 32'hF00F3CA5);
    chk("frame_cnt1", 32'(frame_cnt), 32'd1);
    chk("frame_level1", 32'(fifo_level), 32'd1);
    rx.word_ready = 1'b1;
    step();
    rx.word_ready = 1'b0;
    chk("pop_empty_valid", 32'(rx.word_valid), 32'd0);
    chk("pop_empty_level", 32'(fifo_level), 32'd0);

    // Short frame: fs returns high after 5 bits
    rx.fs = 1'b0;
    repeat (5) step();
    rx.fs = 1'b1;
    step();
    chk("short_set", 32'(short_err), 32'd1);
    chk("short_nopush", 32'(fifo_level), 32'd0);
    chk("short_frames", 32'(frame_cnt), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("short_clr", 32'(short_err), 32'd0);

    // Nine frames into an 8-deep FIFO with no consumer
    do_reset();
    for (int i = 0; i < 9; i++) send_frame(wd(8'(i)), 8, 1'b0, 1'b0);
    chk("ovr_level", 32'(fifo_level), 32'd8);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_frames", 32'(frame_cnt), 32'd9);
    rx.word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), rx.word_data, wd(8'(i)));
      step();
    end
    rx.word_ready = 1'b0;
    chk("drain_valid", 32'(rx.word_valid), 32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);

    // Full FIFO with push and pop in the same cycle
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < 8; i++) send_frame(wd(8'h40 + 8'(i)), 4, 1'b0, 1'b0);
    chk("fill_level", 32'(fifo_level), 32'd8);
    send_frame(32'h99887766, 4, 1'b1, 1'b0);
    chk("pp_level", 32'(fifo_level), 32'd8);
    chk("pp_overrun", 32'(overrun), 32'd0);
    chk("pp_head", rx.word_data, wd(8'h41));
    chk("pp_frames", 32'(frame_cnt), 32'd18);
    rx.word_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("pp_drain_%0d", i), rx.word_data, wd(8'h40 + 8'(i)));
      step();
    end
    chk("pp_last", rx.word_data, 32'h99887766);
    step();
    rx.word_ready = 1'b0;
    chk("pp_empty", 32'(rx.word_valid), 32'd0);

    // Reset asserted during the PUSH cycle
    rx.fs = 1'b0;
    repeat (3) step();
    {rx.lane3, rx.lane2, rx.lane1, rx.lane0} = 32'h12345678;
    rx.take_this = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midpush_valid", 32'(rx.word_valid), 32'd0);
    chk("midpush_level", 32'(fifo_level), 32'd0);
    chk("midpush_frames", 32'(frame_cnt), 32'd0);
    chk("midpush_state", 32'(dut.state), 32'd0);
    rx.fs = 1'b1;
    rx.take_this = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // fs held high in ARMED
    repeat (20) step();
`ifdef SPORT_CTRL_TIMEOUT_EN
    chk("timeout", 32'(link_timeout), 32'd1);
`else
    chk("timeout", 32'(link_timeout), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
